mem_arbiter_2port: RTL and testbench
====================================

// Module: mem_arbiter_2port
// PURPOSE
//  Shares one memory port between two memory requesters, normally the
//  instruction and data ports of a Blimp core, so the core can run on a
//  single-port memory or cache. Requests are merged with round-robin
//  arbitration. Responses return to their originator through an
//  in-order FIFO of requester ids.
// PARAMETERS
//  p_opaq_bits      8  opaque field width of MEM_REQ/MEM_RESP; passed through unchanged
//  p_max_in_flight  4  max outstanding requests; power of two, >= 2
// PORTS
//  clk        input   1    clock
//  rst        input   1    asynchronous, active-low reset
//  req_if[2]  MemIntf server   -   requesters 0/1 (req_val/rdy/msg in, resp_val/rdy/msg out)
//  mem        MemIntf client   -   shared memory (req_val/rdy/msg out, resp_val/rdy/msg in)
// BEHAVIOUR
//  - Request path is combinational (zero latency, no message buffering).
//    The message is muxed from the granted requester; the opaque field is untouched.
//  - Arbitration: 1-bit last_gnt register, reset value 1, so requester 0 wins first.
//    If both req_val are high, grant the requester that is not last_gnt.
//    If one is high, grant it.
//  - full = (count == p_max_in_flight).
//    mem.req_val = (req_val[0] | req_val[1]) & !full.
//    req_if[i].req_rdy = gnt[i] & mem.req_rdy & !full.
//  - On request fire (mem.req_val & mem.req_rdy): push the granted id into id_fifo
//    and set last_gnt <= granted id. last_gnt does not change without a fire.
//  - Memory must return responses in request order. Response routing uses the
//    FIFO head id h.
//    req_if[h].resp_val = mem.resp_val & !empty; the other requester's resp_val = 0.
//    mem.resp_rdy = req_if[h].resp_rdy & !empty.
//    resp_msg is broadcast to both requesters; only resp_val is steered.
//  - On response fire: pop id_fifo.
//  - Simultaneous push and pop: count is unchanged and both pointers advance.
//    full is evaluated before the pop, so no push occurs in a full cycle even if
//    a pop happens.
//  - Pointers are clog2(p_max_in_flight) bits and wrap naturally.
//    count is clog2(p_max_in_flight)+1 bits.
//  - mem.resp_val while empty is a protocol error: response is not accepted
//    (resp_rdy = 0). Assertion fires in simulation.
//  - Reset (async assert, sync deassert externally): count = 0, pointers = 0,
//    last_gnt = 1.
//    All resp_val outputs are 0 while empty. req_rdy/mem.req_val follow the
//    combinational rules above.
//    Reset mid-operation discards outstanding ids; the memory must be reset together.
// STRUCTURE
//  - No new package. Uses the MEM_REQ/MEM_RESP macros with p_opaq_bits.
//  - Sub-module mem_arb_id_fifo: 1-bit-wide synchronous FIFO with
//    push/pop/full/empty/head, depth p_max_in_flight, same clk/rst.
//  - trace(level) function: shows grant, count, and head id, matching harness linetracing.
// TESTING
//  - Req0 LW addr 0x100 only; memory holds 0xdeadbeef ->
//    req_if[0] resp data 0xdeadbeef; req_if[1].resp_val stays 0.
//  - Both requesters hold req_val for 4 cycles with mem always ready ->
//    grants are 0,1,0,1 and responses return to the matching requester.
//  - Memory resp held off; req0 issues 5 back-to-back requests ->
//    first 4 accepted, 5th sees req_rdy = 0 until the first response pops.
//  - Head id = 1 and req_if[1].resp_rdy = 0 for 3 cycles ->
//    mem.resp_rdy = 0 and nothing reaches req 0 during the stall.
//  - Assert rst low with 3 outstanding ->
//    count = 0 immediately, all resp_val = 0, next dual request grants 0 first.
//  - Random source/sink delays (1-5) via MemIntfTestServer, 200 mixed LW/SW per port ->
//    all data matches the FL memory and no response is misrouted.

Source files
------------

// File: rtl/mem_arbiter_2port_pkg.sv
// Shared definitions for the two-port memory arbiter: memory message
// field widths, message type codes and helpers that size the packed
// request/response messages from the opaque field width.
package mem_arbiter_2port_pkg;

  typedef enum logic [2:0] {
    MEM_TYPE_READ  = 3'd0,
    MEM_TYPE_WRITE = 3'd1
  } mem_type_e;

  localparam int MEM_TYPE_BITS = 3;
  localparam int MEM_ADDR_BITS = 32;
  localparam int MEM_LEN_BITS  = 2;
  localparam int MEM_DATA_BITS = 32;
  localparam int MEM_TEST_BITS = 2;

  // Request layout, msb first: type, opaque, addr, len, data
  function automatic int mem_req_bits(input int opaq_bits);
    return MEM_TYPE_BITS + opaq_bits + MEM_ADDR_BITS + MEM_LEN_BITS + MEM_DATA_BITS;
  endfunction

  // Response layout, msb first: type, opaque, test, len, data
  function automatic int mem_resp_bits(input int opaq_bits);
    return MEM_TYPE_BITS + opaq_bits + MEM_TEST_BITS + MEM_LEN_BITS + MEM_DATA_BITS;
  endfunction

endpackage

// File: rtl/mem_arbiter_2port_if.sv
// Memory request/response channel pair with val/rdy handshakes.
// The master issues requests and accepts responses; the slave serves them.
interface mem_arbiter_2port_if #(
  parameter int p_opaq_bits = 8
);
  import mem_arbiter_2port_pkg::*;

  localparam int REQ_W  = mem_req_bits(p_opaq_bits);
  localparam int RESP_W = mem_resp_bits(p_opaq_bits);

  logic              req_val;
  logic              req_rdy;
  logic [REQ_W-1:0]  req_msg;
  logic              resp_val;
  logic              resp_rdy;
  logic [RESP_W-1:0] resp_msg;

  modport master (
    output req_val, req_msg, resp_rdy,
    input  req_rdy, resp_val, resp_msg
  );

  modport slave (
    input  req_val, req_msg, resp_rdy,
    output req_rdy, resp_val, resp_msg
  );

endinterface

// File: rtl/mem_arb_id_fifo.sv
// One-bit-wide in-order FIFO holding the requester id of every request
// that is still waiting for its memory response.
module mem_arb_id_fifo #(
  parameter int p_depth = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    push_id,
  output logic [$clog2(p_depth):0] count,
  output logic                    empty,
  output logic                    head
);

  localparam int PW = $clog2(p_depth);
  localparam int CW = PW + 1;

  logic [p_depth-1:0] ids;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               full;
  logic               do_push;
  logic               do_pop;

  // Status flags and guarded push/pop strobes
  always_comb begin
    full    = (count == CW'(p_depth));
    empty   = (count == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    head    = ids[rd_ptr];
  end

  // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Id storage; entries are only meaningful once written, so no reset needed
  always_ff @(posedge clk) begin
    if (do_push) ids[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/mem_arbiter_2port.sv
// Shares one memory port between two requesters. Requests are merged
// combinationally with round-robin arbitration; responses are steered back
// to their originator using an in-order FIFO of requester ids.
module mem_arbiter_2port
  import mem_arbiter_2port_pkg::*;
#(
  parameter int p_opaq_bits     = 8,
  parameter int p_max_in_flight = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_arbiter_2port_if.slave  req_if [2],
  mem_arbiter_2port_if.master mem
);

  localparam int REQ_W = mem_req_bits(p_opaq_bits);
  localparam int PW    = $clog2(p_max_in_flight);
  localparam int CW    = PW + 1;

  logic [1:0]       req_val;
  logic [1:0]       resp_rdy;
  logic [REQ_W-1:0] req_msg [2];
  logic [1:0]       req_rdy;
  logic [1:0]       resp_val;

  logic [1:0]       gnt;
  logic             gnt_id;
  logic             last_gnt;
  logic             full;
  logic             empty;
  logic             head;
  logic [CW-1:0]    count;
  logic             req_fire;
  logic             resp_fire;

  for (genvar i = 0; i < 2; i++) begin : g_port
    assign req_val[i]         = req_if[i].req_val;
    assign req_msg[i]         = req_if[i].req_msg;
    assign resp_rdy[i]        = req_if[i].resp_rdy;
    assign req_if[i].req_rdy  = req_rdy[i];
    assign req_if[i].resp_val = resp_val[i];
    assign req_if[i].resp_msg = mem.resp_msg;
  end

  // Round-robin grant: on contention the requester that did not win last goes
  assign full = (count == CW'(p_max_in_flight));

  always_comb begin
    gnt[0]    = req_val[0] & (~req_val[1] | last_gnt);
    gnt[1]    = req_val[1] & (~req_val[0] | ~last_gnt);
    gnt_id    = gnt[1];
    req_rdy   = gnt & {2{mem.req_rdy & ~full}};
    req_fire  = (req_val[0] | req_val[1]) & ~full & mem.req_rdy;
    resp_val  = '0;
    resp_val[head] = mem.resp_val & ~empty;
    resp_fire = mem.resp_val & resp_rdy[head] & ~empty;
  end

  assign mem.req_val  = (req_val[0] | req_val[1]) & ~full;
  assign mem.req_msg  = gnt_id ? req_msg[1] : req_msg[0];
  assign mem.resp_rdy = resp_rdy[head] & ~empty;

  // Remember who won the last accepted request; idle cycles leave it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        last_gnt <= 1'b1;
    else if (req_fire) last_gnt <= gnt_id;
  end

  mem_arb_id_fifo #(
    .p_depth (p_max_in_flight)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (req_fire),
    .pop     (resp_fire),
    .push_id (gnt_id),
    .count   (count),
    .empty   (empty),
    .head    (head)
  );

  // Packed line-trace word: grant, occupancy (only at level > 0), head id
  function automatic logic [CW+1:0] trace(input int level);
    if (level > 0) return {gnt_id, count, head};
    return {gnt_id, {CW{1'b0}}, head};
  endfunction

  // A response with nothing outstanding means the memory broke ordering
  assert property (@(posedge clk) disable iff (!rst_n) !(mem.resp_val && empty))
    else $error("mem_arbiter_2port: memory response with no outstanding request");

endmodule

// File: tb/tb_mem_arbiter_2port.sv
// Self-checking bench for mem_arbiter_2port: an in-order behavioural memory
// and a transaction-level model predict every handshake, grant and routed
// response cycle by cycle under directed and randomized traffic.
module tb_mem_arbiter_2port;
  import mem_arbiter_2port_pkg::*;

  localparam int OPAQ   = 8;
  localparam int DEPTH  = 4;
  localparam int REQ_W  = mem_req_bits(OPAQ);
  localparam int RESP_W = mem_resp_bits(OPAQ);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_2port_if #(.p_opaq_bits(OPAQ)) req_if [2] ();
  mem_arbiter_2port_if #(.p_opaq_bits(OPAQ)) mem ();

  mem_arbiter_2port #(
    .p_opaq_bits     (OPAQ),
    .p_max_in_flight (DEPTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_if (req_if),
    .mem    (mem)
  );

  logic [1:0]        drv_req_val = '0;
  logic [1:0]        drv_resp_rdy = '0;
  logic [REQ_W-1:0]  drv_req_msg [2];
  logic              drv_mem_req_rdy = 1'b0;
  logic              drv_mem_resp_val = 1'b0;
  logic [RESP_W-1:0] drv_mem_resp_msg = '0;
  logic [1:0]        obs_req_rdy;
  logic [1:0]        obs_resp_val;
  logic [RESP_W-1:0] obs_resp_msg [2];

  for (genvar g = 0; g < 2; g++) begin : g_conn
    assign req_if[g].req_val  = drv_req_val[g];
    assign req_if[g].req_msg  = drv_req_msg[g];
    assign req_if[g].resp_rdy = drv_resp_rdy[g];
    assign obs_req_rdy[g]     = req_if[g].req_rdy;
    assign obs_resp_val[g]    = req_if[g].resp_val;
    assign obs_resp_msg[g]    = req_if[g].resp_msg;
  end

  assign mem.req_rdy  = drv_mem_req_rdy;
  assign mem.resp_val = drv_mem_resp_val;
  assign mem.resp_msg = drv_mem_resp_msg;

  // Reference model state: outstanding transactions in memory order
  typedef struct packed {
    logic              id;
    logic [RESP_W-1:0] resp;
  } flight_t;

  flight_t          flight_q [$];
  logic [31:0]      fl_mem [256];
  logic             last_winner;
  logic             has_cur [2];
  logic [REQ_W-1:0] cur [2];
  int               issued [2];
  int               seq [2];
  int               p_req [2];
  int               p_rr [2];
  int               p_mrdy;
  int               p_mval;
  logic             req_fire_m;
  logic             resp_fire_m;
  logic             winner_m;
  int               gnt_log [$];
  int               dut_fires;
  logic             got_resp0;
  logic [31:0]      last_resp0;

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
  endtask

  task automatic newMsg(input int port);
    logic [2:0]  t;
    logic [31:0] addr;
    logic [31:0] data;
    t    = ($urandom_range(1) == 1) ? MEM_TYPE_WRITE : MEM_TYPE_READ;
    addr = 32'($urandom_range(63)) << 2;
    data = $urandom;
    cur[port]     = {t, 1'(port), 7'(seq[port]), addr, 2'b00, data};
    seq[port]     = seq[port] + 1;
    has_cur[port] = 1'b1;
  endtask

  // Behavioural single-port memory: reads return the stored word, writes return zero
  task automatic memServe(input logic [REQ_W-1:0] msg, output logic [RESP_W-1:0] resp);
    logic [2:0]  t;
    logic [7:0]  opaq;
    logic [31:0] addr;
    logic [31:0] rdata;
    t     = msg[REQ_W-1 -: 3];
    opaq  = msg[REQ_W-4 -: 8];
    addr  = msg[65:34];
    rdata = '0;
    if (t == MEM_TYPE_WRITE) fl_mem[addr[9:2]] = msg[31:0];
    else                     rdata = fl_mem[addr[9:2]];
    resp = {t, opaq, 2'b00, 2'b00, rdata};
  endtask

  // Predict this cycle's combinational outputs from the transaction model
  task automatic checkCycle();
    logic full_m;
    logic any_m;
    logic exp_mval;
    logic nonempty;
    logic h;
    logic exp_rr;
    full_m = (flight_q.size() == DEPTH);
    any_m  = has_cur[0] | has_cur[1];
    if (has_cur[0] && has_cur[1]) winner_m = ~last_winner;
    else                          winner_m = has_cur[1];
    exp_mval = any_m && !full_m;
    checkOutput("mem_req_val", mem.req_val, exp_mval);
    if (exp_mval) checkOutput("mem_req_msg", mem.req_msg, cur[winner_m]);
    for (int i = 0; i < 2; i++)
      checkOutput($sformatf("req_rdy%0d", i), obs_req_rdy[i],
                  exp_mval && (winner_m == 1'(i)) && drv_mem_req_rdy);
    nonempty = (flight_q.size() > 0);
    h        = nonempty ? flight_q[0].id : 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("resp_val%0d", i), obs_resp_val[i],
                  drv_mem_resp_val && nonempty && (h == 1'(i)));
      if (drv_mem_resp_val && nonempty)
        checkOutput($sformatf("resp_msg%0d", i), obs_resp_msg[i], flight_q[0].resp);
    end
    exp_rr = nonempty && drv_resp_rdy[h];
    checkOutput("mem_resp_rdy", mem.resp_rdy, exp_rr);
    req_fire_m  = exp_mval && drv_mem_req_rdy;
    resp_fire_m = drv_mem_resp_val && exp_rr;
    if (obs_req_rdy != 2'b00) gnt_log.push_back(obs_req_rdy[1] ? 1 : 0);
    if (mem.req_val && drv_mem_req_rdy) dut_fires++;
    if (resp_fire_m && h == 1'b0) begin
      got_resp0  = 1'b1;
      last_resp0 = obs_resp_msg[0][31:0];
    end
  endtask

  task automatic updateModel();
    flight_t f;
    if (resp_fire_m) void'(flight_q.pop_front());
    if (req_fire_m) begin
      f.id = winner_m;
      memServe(cur[winner_m], f.resp);
      flight_q.push_back(f);
      last_winner       = winner_m;
      has_cur[winner_m] = 1'b0;
      issued[winner_m]  = issued[winner_m] + 1;
    end
  endtask

  // One clock of traffic: drive at the falling edge, check, advance the model
  task automatic applyStimulus();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!has_cur[i] && $urandom_range(99) < p_req[i]) newMsg(i);
      drv_req_val[i]  = has_cur[i];
      drv_req_msg[i]  = cur[i];
      drv_resp_rdy[i] = ($urandom_range(99) < p_rr[i]);
    end
    drv_mem_req_rdy  = ($urandom_range(99) < p_mrdy);
    drv_mem_resp_val = (flight_q.size() > 0) && ($urandom_range(99) < p_mval);
    drv_mem_resp_msg = (flight_q.size() > 0) ? flight_q[0].resp : '0;
    #1;
    checkCycle();
    @(posedge clk);
    updateModel();
  endtask

  task automatic setKnobs(input int r0, input int r1, input int mrdy, input int mval,
                          input int rr0, input int rr1);
    p_req[0] = r0;  p_req[1] = r1;
    p_mrdy   = mrdy; p_mval  = mval;
    p_rr[0]  = rr0; p_rr[1]  = rr1;
  endtask

  task automatic drain();
    int n;
    setKnobs(0, 0, 100, 100, 100, 100);
    n = 0;
    while ((flight_q.size() > 0 || has_cur[0] || has_cur[1]) && n < 200) begin
      applyStimulus();
      n++;
    end
    if (flight_q.size() > 0 || has_cur[0] || has_cur[1])
      checkOutput("drain_timeout", 128'(flight_q.size()), 128'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) fl_mem[i] = 32'h1000_0000 + 32'(i);
    fl_mem[64] = 32'hdead_beef;
    for (int i = 0; i < 2; i++) begin
      has_cur[i] = 1'b0; cur[i] = '0; issued[i] = 0; seq[i] = 0;
      drv_req_msg[i] = '0;
    end
    last_winner = 1'b1;
    dut_fires   = 0;
    got_resp0   = 1'b0;
    last_resp0  = '0;

    // Quiet outputs while held in reset
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_mem_req_val", mem.req_val, 1'b0);
    checkOutput("rst_req_rdy", obs_req_rdy, 2'b00);
    checkOutput("rst_resp_val", obs_resp_val, 2'b00);
    checkOutput("rst_mem_resp_rdy", mem.resp_rdy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention with an always-ready memory alternates 0,1,0,1
    $display("[TB] dual requesters alternating");
    gnt_log.delete();
    setKnobs(100, 100, 100, 100, 100, 100);
    repeat (6) applyStimulus();
    n = gnt_log.size();
    checkOutput("alt_grant_count", 128'(n >= 4), 128'd1);
    for (int i = 0; i < 4 && i < n; i++)
      checkOutput($sformatf("alt_grant%0d", i), 128'(gnt_log[i]), 128'(i % 2));
    drain();

    // Single LW from requester 0 returns the preloaded word
    $display("[TB] single load from requester 0");
    cur[0]     = {MEM_TYPE_READ, 1'b0, 7'(seq[0]), 32'h0000_0100, 2'b00, 32'h0};
    seq[0]     = seq[0] + 1;
    has_cur[0] = 1'b1;
    got_resp0  = 1'b0;
    setKnobs(0, 0, 100, 100, 100, 100);
    n = 0;
    while (!got_resp0 && n < 10) begin
      applyStimulus();
      n++;
    end
    checkOutput("lw_resp_seen", got_resp0, 1'b1);
    checkOutput("lw_0x100_data", last_resp0, 32'hdead_beef);
    drain();

    // Responses held off: only four requests fit in flight
    $display("[TB] in-flight limit");
    n = dut_fires;
    setKnobs(100, 0, 100, 0, 100, 100);
    repeat (6) applyStimulus();
    checkOutput("full_accepted", 128'(dut_fires - n), 128'd4);
    checkOutput("full_blocks_req", obs_req_rdy[0], 1'b0);
    setKnobs(100, 0, 100, 100, 100, 100);
    applyStimulus();
    checkOutput("full_no_push_on_pop", obs_req_rdy[0], 1'b0);
    setKnobs(100, 0, 100, 0, 100, 100);
    applyStimulus();
    checkOutput("full_reopens", obs_req_rdy[0], 1'b1);
    drain();

    // Head belongs to requester 1, which stalls its response channel
    $display("[TB] response stall on requester 1");
    setKnobs(0, 100, 100, 0, 100, 100);
    applyStimulus();
    setKnobs(100, 0, 100, 0, 100, 100);
    while (has_cur[0] || flight_q.size() < 2) applyStimulus();
    setKnobs(0, 0, 100, 100, 100, 0);
    repeat (3) begin
      applyStimulus();
      checkOutput("stall_mem_resp_rdy", mem.resp_rdy, 1'b0);
      checkOutput("stall_resp_val0", obs_resp_val[0], 1'b0);
      checkOutput("stall_resp_val1", obs_resp_val[1], 1'b1);
    end
    drain();

    // Reset with three requests outstanding
    $display("[TB] reset mid-operation");
    setKnobs(100, 0, 100, 0, 100, 100);
    n = 0;
    while (flight_q.size() < 3 && n < 20) begin
      applyStimulus();
      n++;
    end
    @(negedge clk);
    rst_n            = 1'b0;
    drv_req_val      = 2'b11;
    drv_mem_req_rdy  = 1'b1;
    drv_mem_resp_val = 1'b1;
    drv_resp_rdy     = 2'b11;
    #1;
    checkOutput("mid_rst_resp_val", obs_resp_val, 2'b00);
    checkOutput("mid_rst_mem_resp_rdy", mem.resp_rdy, 1'b0);
    checkOutput("mid_rst_mem_req_val", mem.req_val, 1'b1);
    checkOutput("mid_rst_req_rdy", obs_req_rdy, 2'b01);
    flight_q.delete();
    last_winner = 1'b1;
    has_cur[0]  = 1'b0;
    has_cur[1]  = 1'b0;
    @(negedge clk);
    rst_n            = 1'b1;
    drv_req_val      = 2'b00;
    drv_mem_resp_val = 1'b0;
    gnt_log.delete();
    setKnobs(100, 100, 100, 100, 100, 100);
    repeat (2) applyStimulus();
    checkOutput("post_rst_first_grant", 128'(gnt_log.size() > 0 ? gnt_log[0] : 9), 128'd0);
    drain();

    // Randomized mixed traffic with random handshake delays on every side
    $display("[TB] random traffic");
    n = 0;
    begin
      int start0;
      int start1;
      start0 = issued[0];
      start1 = issued[1];
      while ((issued[0] - start0 < 200 || issued[1] - start1 < 200) && n < 20000) begin
        setKnobs($urandom_range(30, 90), $urandom_range(30, 90),
                 $urandom_range(20, 100), $urandom_range(20, 100),
                 $urandom_range(20, 100), $urandom_range(20, 100));
        applyStimulus();
        n++;
      end
      if (n >= 20000) checkOutput("random_timeout", 128'(n), 128'd0);
    end
    drain();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
